// File: rtl/pipelined_cla_addsub.sv
// -----------------------------------------------------------------------------
// pipelined_cla_addsub
//
// Three-stage pipelined adder/subtractor built on a two-level carry-lookahead
// structure. Level 1 forms bit generate/propagate and 4-bit group G/P. Level 2
// resolves the group carries from G/P.
//   S1: holds A, B^{as}, as.  Combinationally forms g/p and group G/P.
//   S2: holds g, p, G, P, c0. Combinationally forms group carries C[GROUPS:1].
//   S3: holds g, p and the group carries. Combinationally forms sum/cout/ovf.
// A valid/ready handshake runs alongside. Each stage loads whenever it is empty
// or its successor is moving, so empty stages never stall upstream traffic.
//
// Optional feature macro: CLA_SATURATE_EN
//   When it is defined, a signed overflow saturates sum to the limit selected
//   by A's sign bit. cout and ovf still describe the unsaturated result.
//   When it is undefined, sum wraps modulo 2^WIDTH.
//
// Parameters
//   WIDTH      operand/result width, a multiple of 4 in the range 8..64
// Ports
//   clk        rising-edge clock
//   rst        asynchronous active-high reset; clears all valid and data flops
//   in_valid   operands presented on in_a/in_b/as
//   in_ready   stage 1 can accept this cycle
//   in_a       operand A
//   in_b       operand B
//   as         0: A+B, 1: A-B (B inverted, carry-in 1)
//   out_valid  result valid
//   out_ready  consumer accepts the result
//   sum        result
//   cout       carry out of the MSB; on subtract, 1 means no borrow
//   ovf        signed overflow (carry into MSB XOR carry out of MSB)
// -----------------------------------------------------------------------------
module pipelined_cla_addsub #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             as,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int GROUPS = WIDTH / 4;
  // Bit 3 of every group's generate is fully absorbed into the group G in S1.
  // Only bits 0..2 of each group are still needed for the in-group carries.
  localparam int GLO = 3 * GROUPS;

  // ---------------- stage registers ----------------
  logic               v1_q, v1_d;
  logic [WIDTH-1:0]   a1_q, a1_d;
  logic [WIDTH-1:0]   bx1_q, bx1_d;
  logic               c0_1_q, c0_1_d;

  logic               v2_q, v2_d;
  logic [GLO-1:0]     g2_q, g2_d;
  logic [WIDTH-1:0]   p2_q, p2_d;
  logic [GROUPS-1:0]  gg2_q, gg2_d;
  logic [GROUPS-1:0]  gp2_q, gp2_d;
  logic               c0_2_q, c0_2_d;

  logic               v3_q, v3_d;
  logic [GLO-1:0]     g3_q, g3_d;
  logic [WIDTH-1:0]   p3_q, p3_d;
  logic [GROUPS:0]    c3_q, c3_d;

`ifdef CLA_SATURATE_EN
  logic               sign2_q, sign2_d;
  logic               sign3_q, sign3_d;
`endif

  // ---------------- combinational nets ----------------
  logic               en1_s, en2_s, en3_s;
  logic [WIDTH-1:0]   g1_s, p1_s;
  logic [GLO-1:0]     glo1_s;
  logic [GROUPS-1:0]  gg1_s, gp1_s;
  logic [GROUPS:0]    c2_s;
  logic [WIDTH-1:0]   cint_s;
  logic [WIDTH-1:0]   sum_raw_s, sum_s;
  logic               cout_s, ovf_s;

  // Load enables: a stage may load when it is empty or its successor moves.
  always_comb begin
    en3_s = ~v3_q | out_ready;
    en2_s = ~v2_q | en3_s;
    en1_s = ~v1_q | en2_s;
  end

  assign in_ready  = en1_s;
  assign out_valid = v3_q;

  // Stage 1 next state: capture operands with B already conditionally inverted.
  always_comb begin
    v1_d   = v1_q;
    a1_d   = a1_q;
    bx1_d  = bx1_q;
    c0_1_d = c0_1_q;
    if (en1_s) begin
      v1_d = in_valid;
      if (in_valid) begin
        a1_d   = in_a;
        bx1_d  = in_b ^ {WIDTH{as}};
        c0_1_d = as;
      end else begin
        a1_d   = a1_q;
      end
    end else begin
      v1_d = v1_q;
    end
  end

  assign g1_s = a1_q & bx1_q;
  assign p1_s = a1_q ^ bx1_q;

  // Level 1 lookahead: 4-bit group generate/propagate from S1 bit g/p.
  always_comb begin
    gg1_s  = '0;
    gp1_s  = '0;
    glo1_s = '0;
    for (int i = 0; i < GROUPS; i++) begin
      gg1_s[i] = g1_s[4*i+3]
               | (p1_s[4*i+3] & g1_s[4*i+2])
               | (p1_s[4*i+3] & p1_s[4*i+2] & g1_s[4*i+1])
               | (p1_s[4*i+3] & p1_s[4*i+2] & p1_s[4*i+1] & g1_s[4*i]);
      gp1_s[i] = &p1_s[4*i +: 4];
      glo1_s[3*i +: 3] = g1_s[4*i +: 3];
    end
  end

  // Stage 2 next state: capture g/p, group G/P and the group-0 carry-in.
  always_comb begin
    v2_d   = v2_q;
    g2_d   = g2_q;
    p2_d   = p2_q;
    gg2_d  = gg2_q;
    gp2_d  = gp2_q;
    c0_2_d = c0_2_q;
`ifdef CLA_SATURATE_EN
    sign2_d = sign2_q;
`endif
    if (en2_s) begin
      v2_d = v1_q;
      if (v1_q) begin
        g2_d   = glo1_s;
        p2_d   = p1_s;
        gg2_d  = gg1_s;
        gp2_d  = gp1_s;
        c0_2_d = c0_1_q;
`ifdef CLA_SATURATE_EN
        sign2_d = a1_q[WIDTH-1];
`endif
      end else begin
        g2_d = g2_q;
      end
    end else begin
      v2_d = v2_q;
    end
  end

  // Level 2 lookahead: group carries from group G/P and c0.
  always_comb begin : s2_carry
    logic acc;
    acc     = c0_2_q;
    c2_s    = '0;
    c2_s[0] = c0_2_q;
    for (int i = 0; i < GROUPS; i++) begin
      acc       = gg2_q[i] | (gp2_q[i] & acc);
      c2_s[i+1] = acc;
    end
  end

  // Stage 3 next state: capture g/p with the resolved group carries.
  always_comb begin
    v3_d = v3_q;
    g3_d = g3_q;
    p3_d = p3_q;
    c3_d = c3_q;
`ifdef CLA_SATURATE_EN
    sign3_d = sign3_q;
`endif
    if (en3_s) begin
      v3_d = v2_q;
      if (v2_q) begin
        g3_d = g2_q;
        p3_d = p2_q;
        c3_d = c2_s;
`ifdef CLA_SATURATE_EN
        sign3_d = sign2_q;
`endif
      end else begin
        g3_d = g3_q;
      end
    end else begin
      v3_d = v3_q;
    end
  end

  // In-group lookahead carries into every bit, seeded by each group carry-in.
  always_comb begin
    cint_s = '0;
    for (int i = 0; i < GROUPS; i++) begin
      cint_s[4*i]   = c3_q[i];
      cint_s[4*i+1] = g3_q[3*i] | (p3_q[4*i] & c3_q[i]);
      cint_s[4*i+2] = g3_q[3*i+1]
                    | (p3_q[4*i+1] & g3_q[3*i])
                    | (p3_q[4*i+1] & p3_q[4*i] & c3_q[i]);
      cint_s[4*i+3] = g3_q[3*i+2]
                    | (p3_q[4*i+2] & g3_q[3*i+1])
                    | (p3_q[4*i+2] & p3_q[4*i+1] & g3_q[3*i])
                    | (p3_q[4*i+2] & p3_q[4*i+1] & p3_q[4*i] & c3_q[i]);
    end
  end

  // Result: sum = p ^ carry-in per bit. ovf compares the carries around the MSB.
  always_comb begin
    sum_raw_s = p3_q ^ cint_s;
    cout_s    = c3_q[GROUPS];
    ovf_s     = cint_s[WIDTH-1] ^ c3_q[GROUPS];
`ifdef CLA_SATURATE_EN
    if (ovf_s) begin
      if (sign3_q) begin
        sum_s = {1'b1, {(WIDTH-1){1'b0}}};
      end else begin
        sum_s = {1'b0, {(WIDTH-1){1'b1}}};
      end
    end else begin
      sum_s = sum_raw_s;
    end
`else
    sum_s = sum_raw_s;
`endif
  end

  assign sum  = sum_s;
  assign cout = cout_s;
  assign ovf  = ovf_s;

  // Pipeline state registers. Reset discards every in-flight operation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1_q    <= 1'b0;
      a1_q    <= '0;
      bx1_q   <= '0;
      c0_1_q  <= 1'b0;
      v2_q    <= 1'b0;
      g2_q    <= '0;
      p2_q    <= '0;
      gg2_q   <= '0;
      gp2_q   <= '0;
      c0_2_q  <= 1'b0;
      v3_q    <= 1'b0;
      g3_q    <= '0;
      p3_q    <= '0;
      c3_q    <= '0;
`ifdef CLA_SATURATE_EN
      sign2_q <= 1'b0;
      sign3_q <= 1'b0;
`endif
    end else begin
      v1_q    <= v1_d;
      a1_q    <= a1_d;
      bx1_q   <= bx1_d;
      c0_1_q  <= c0_1_d;
      v2_q    <= v2_d;
      g2_q    <= g2_d;
      p2_q    <= p2_d;
      gg2_q   <= gg2_d;
      gp2_q   <= gp2_d;
      c0_2_q  <= c0_2_d;
      v3_q    <= v3_d;
      g3_q    <= g3_d;
      p3_q    <= p3_d;
      c3_q    <= c3_d;
`ifdef CLA_SATURATE_EN
      sign2_q <= sign2_d;
      sign3_q <= sign3_d;
`endif
    end
  end

endmodule
